incubator_sensor_scheduler: RTL and testbench

//   Front-end scheduler for the Incubator controller. Polls NUM_SENSORS temperature probes

---
 rtl/incubator_sensor_scheduler.sv | 125 ++++++++++++
 tb/tb_incubator_sensor_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/incubator_sensor_scheduler.sv
// rtl/incubator_sensor_scheduler.sv - round-robin probe poller with range/timeout rejection and averaging
module incubator_sensor_scheduler #(
  parameter int NUM_SENSORS   = 4,
  parameter int SAMPLE_PERIOD = 64,
  parameter int TIMEOUT       = 8,
  parameter int T_MIN         = -10,
  parameter int T_MAX         = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [NUM_SENSORS-1:0]     sens_req,
  input  logic [NUM_SENSORS-1:0]     sens_ack,
  input  logic [8*NUM_SENSORS-1:0]   sens_data,
  output logic signed [7:0]          temperature,
  output logic                       temp_valid,
  output logic [NUM_SENSORS-1:0]     sensor_fault,
  output logic                       all_fault,
  output logic                       overrun
);

  localparam int LOG = $clog2(NUM_SENSORS);
  localparam int AW  = 8 + LOG;
  localparam int CW  = $clog2(SAMPLE_PERIOD);
  localparam int WW  = $clog2(TIMEOUT) + 1;
  localparam logic signed [7:0] TMIN8 = 8'(T_MIN);
  localparam logic signed [7:0] TMAX8 = 8'(T_MAX);

  typedef enum logic [1:0] {IDLE, REQ, NEXT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    tick;
  logic [LOG-1:0]          idx;
  logic [WW-1:0]           wait_cnt;
  logic signed [AW-1:0]    acc;
  logic [NUM_SENSORS-1:0]  fault;
  logic signed [7:0]       sel_data;
  logic signed [7:0]       addend;
  logic signed [AW-1:0]    addend_ext;
  logic                    ack_sel, d_ok, timed_out, last_probe;

  assign tick       = (cnt == CW'(SAMPLE_PERIOD - 1));
  assign ack_sel    = sens_ack[idx];
  assign d_ok       = (sel_data >= TMIN8) && (sel_data <= TMAX8);
  assign timed_out  = (wait_cnt == WW'(TIMEOUT - 1));
  assign last_probe = (idx == LOG'(NUM_SENSORS - 1));
  // Rejected or missing readings are replaced by the last published value
  assign addend     = (ack_sel && d_ok) ? sel_data : temperature;
  assign addend_ext = {{LOG{addend[7]}}, addend};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      if (idx == LOG'(i)) sel_data = sens_data[8*i +: 8];
  end

  always_comb begin
    sens_req = '0;
    if (state == REQ) sens_req[idx] = 1'b1;
  end

  assign temp_valid = (state == DONE) && !(&fault);
  assign overrun    = tick && (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tick) state_nxt = REQ;
      REQ:  if (ack_sel || timed_out) state_nxt = NEXT;
      NEXT: state_nxt = last_probe ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      wait_cnt     <= '0;
      acc          <= '0;
      fault        <= '0;
      temperature  <= '0;
      sensor_fault <= '0;
      all_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          idx      <= '0;
          wait_cnt <= '0;
          acc      <= '0;
          fault    <= '0;
        end
        REQ: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (ack_sel || timed_out) begin
            acc        <= acc + addend_ext;
            fault[idx] <= !(ack_sel && d_ok);
          end
        end
        NEXT: if (!last_probe) begin
          idx      <= idx + LOG'(1);
          wait_cnt <= '0;
        end
        DONE: begin
          // Upper slice of the sum is the floor-divided mean
          if (!(&fault)) temperature <= acc[LOG+7:LOG];
          sensor_fault <= fault;
          all_fault    <= &fault;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_incubator_sensor_scheduler.sv
// tb/tb_incubator_sensor_scheduler.sv - scoreboard bench for incubator_sensor_scheduler
module tb_incubator_sensor_scheduler;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        sens_req, sens_ack, resp_ack, stray, sensor_fault;
  logic [31:0]       sens_data;
  logic signed [7:0] temperature;
  logic              temp_valid, all_fault, overrun;

  logic [3:0]        req16, fault16;
  logic signed [7:0] temp16;
  logic              valid16, all16, ovr16;

  typedef struct {
    logic signed [7:0] temp;
    logic [3:0]        fault;
    logic              valid;
  } exp_t;
  exp_t sb[$];

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  alive = 4'b0000;
  int          seen[4] = '{0, 0, 0, 0};
  int          last_temp = 0;
  int          run2 = 0, last_run2 = 0;
  int          ovr_cnt = 0, ovr_wide = 0, main_ovr = 0;
  logic        ovr16_prev = 1'b0;

  assign sens_ack = resp_ack | stray;

  incubator_sensor_scheduler dut (
    .clk(clk), .reset(reset), .sens_req(sens_req), .sens_ack(sens_ack),
    .sens_data(sens_data), .temperature(temperature), .temp_valid(temp_valid),
    .sensor_fault(sensor_fault), .all_fault(all_fault), .overrun(overrun)
  );

  incubator_sensor_scheduler #(.SAMPLE_PERIOD(16)) dut16 (
    .clk(clk), .reset(reset), .sens_req(req16), .sens_ack(4'b0000),
    .sens_data(32'h0), .temperature(temp16), .temp_valid(valid16),
    .sensor_fault(fault16), .all_fault(all16), .overrun(ovr16)
  );

  always #5 clk = ~clk;

  // Probe model: live probes answer one cycle after their request rises
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sens_req[i]) seen[i] = seen[i] + 1;
      else             seen[i] = 0;
      resp_ack[i] = alive[i] && sens_req[i] && (seen[i] >= 2);
    end
    if (sens_req[2]) run2 = run2 + 1;
    else if (run2 != 0) begin
      last_run2 = run2;
      run2 = 0;
    end
    if (ovr16) ovr_cnt = ovr_cnt + 1;
    if (ovr16 && ovr16_prev) ovr_wide = ovr_wide + 1;
    ovr16_prev = ovr16;
    if (overrun) main_ovr = main_ovr + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_round(input int d0, input int d1, input int d2, input int d3, input logic [3:0] al);
    int d[4];
    int sum;
    exp_t e;
    d = '{d0, d1, d2, d3};
    sum = 0;
    e.fault = '0;
    for (int i = 0; i < 4; i++) begin
      sens_data[8*i +: 8] = 8'(d[i]);
      if (al[i] && d[i] >= -10 && d[i] <= 60) sum += d[i];
      else begin
        sum += last_temp;
        e.fault[i] = 1'b1;
      end
    end
    alive = al;
    e.valid = !(&e.fault);
    if (e.valid) last_temp = sum >>> 2;
    e.temp = 8'(last_temp);
    sb.push_back(e);
  endtask

  task automatic wait_req(input int bit_i, input logic level, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sens_req[bit_i] === level) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic collect(input string tag);
    bit ok1, ok2;
    exp_t e;
    wait_req(3, 1'b1, ok1);
    wait_req(3, 1'b0, ok2);
    chk({tag, "_round_end"}, 32'(ok1 && ok2), 32'd1);
    e = sb.pop_front();
    @(negedge clk);
    chk({tag, "_temp_valid"}, 32'(temp_valid), 32'(e.valid));
    @(negedge clk);
    chk({tag, "_temperature"}, temperature, e.temp);
    chk({tag, "_sensor_fault"}, 32'(sensor_fault), 32'(e.fault));
    chk({tag, "_all_fault"}, 32'(all_fault), 32'(&e.fault));
  endtask

  initial begin
    bit ok;
    int n;
    stray = 4'b0000;
    sens_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(sens_req), 0);
    chk("rst_temp", temperature, 0);
    chk("rst_valid", 32'(temp_valid), 0);
    chk("rst_fault", 32'(sensor_fault), 0);
    chk("rst_all_fault", 32'(all_fault), 0);
    chk("rst_overrun", 32'(overrun), 0);

    set_round(10, 11, 12, 13, 4'b1111);
    reset = 1'b1;
    n = 0;
    while (sens_req === 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_latency", n, 64);
    chk("first_req_onehot", 32'(sens_req), 32'd1);
    collect("happy");

    set_round(-3, -2, -2, -2, 4'b1111);
    collect("neg_floor");
    set_round(16, 16, 16, 16, 4'b1111);
    collect("prime16");
    set_round(20, 20, 0, 20, 4'b1011);
    collect("timeout");
    chk("timeout_req2_width", last_run2, 8);
    set_round(30, 30, 30, 30, 4'b1111);
    collect("prime30");
    set_round(90, 30, 30, 30, 4'b1111);
    collect("range_reject");
    set_round(40, 40, 40, 40, 4'b1111);
    collect("fault_clear");

    set_round(25, 25, 25, 25, 4'b0000);
    wait_req(2, 1'b1, ok);
    chk("dead_reach_probe2", 32'(ok), 1);
    stray = 4'b0001;
    collect("all_dead");
    stray = 4'b0000;

    chk("ovr16_seen", 32'(ovr_cnt > 0), 1);
    chk("ovr16_pulse_width", ovr_wide, 0);
    chk("ovr16_all_fault", 32'(all16), 1);
    chk("main_no_overrun", main_ovr, 0);

    wait_req(1, 1'b1, ok);
    chk("mid_reach_req", 32'(ok), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(sens_req), 0);
    chk("mid_rst_temp", temperature, 0);
    chk("mid_rst_fault", 32'(sensor_fault), 0);
    chk("mid_rst_all_fault", 32'(all_fault), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(sens_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
